// File: rtl/led_breath_seq_if.sv
// Control and duty bus of the LED breathing sequencer.
// The host drives the run controls; the sequencer returns duty and status.
interface led_breath_seq_if #(
  parameter int DUTY_WIDTH     = 8,
  parameter int STEP_DIV_WIDTH = 24,
  parameter int HOLD_WIDTH     = 8
);
  logic                      in_enable;
  logic [STEP_DIV_WIDTH-1:0] in_step_div;
  logic [HOLD_WIDTH-1:0]     in_hold_steps;
  logic [DUTY_WIDTH-1:0]     out_duty;
  logic                      out_step;
  logic [2:0]                out_phase;
  logic                      out_cycle_done;

  modport master (
    output in_enable,
    output in_step_div,
    output in_hold_steps,
    input  out_duty,
    input  out_step,
    input  out_phase,
    input  out_cycle_done
  );

  modport slave (
    input  in_enable,
    input  in_step_div,
    input  in_hold_steps,
    output out_duty,
    output out_step,
    output out_phase,
    output out_cycle_done
  );
endinterface

// File: rtl/led_breath_seq.sv
// Breathing duty sequencer: ramp up, dwell high, ramp down, dwell low.
// Feeds the PWM generator's duty input directly.
module led_breath_seq #(
  parameter int DUTY_WIDTH     = 8,
  parameter int STEP_DIV_WIDTH = 24,
  parameter int HOLD_WIDTH     = 8
) (
  input  logic            in_clk,
  input  logic            in_rst,
  led_breath_seq_if.slave bus
);

  localparam logic [DUTY_WIDTH-1:0] DMAX = '1;
  localparam logic [DUTY_WIDTH-1:0] ONE  = DUTY_WIDTH'(1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RISE    = 3'd1,
    HOLD_HI = 3'd2,
    FALL    = 3'd3,
    HOLD_LO = 3'd4
  } state_t;

  state_t                    state_q, state_d;
  logic [DUTY_WIDTH-1:0]     duty_q, duty_d;
  logic [STEP_DIV_WIDTH-1:0] pre_q, pre_d;
  logic [HOLD_WIDTH-1:0]     hold_q, hold_d;
  logic                      step_q, step_d;
  logic                      done_q, done_d;

  logic                      tick;
  logic                      hold_end;
  logic                      up_step;
  logic                      up_last;
  logic [DUTY_WIDTH-1:0]     dn_duty;
  logic                      dn_step;
  logic                      dn_last;

  // ">=" so a lowered divider fires at once instead of wrapping
  assign tick     = (state_q != IDLE) &&
                    (pre_q >= bus.in_step_div);
  assign hold_end = (hold_q == bus.in_hold_steps);

  assign up_step  = (duty_q != DMAX);
  assign up_last  = (duty_q >= DMAX - ONE);
  assign dn_step  = (duty_q != '0);
  assign dn_duty  = dn_step ? duty_q - ONE : '0;
  assign dn_last  = (duty_q <= ONE);

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      state_q <= IDLE;
      duty_q  <= '0;
      pre_q   <= '0;
      hold_q  <= '0;
      step_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      duty_q  <= duty_d;
      pre_q   <= pre_d;
      hold_q  <= hold_d;
      step_q  <= step_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    duty_d  = duty_q;
    pre_d   = '0;
    hold_d  = hold_q;
    step_d  = 1'b0;
    done_d  = 1'b0;
    if (state_q != IDLE && !tick) begin
      pre_d = pre_q + 1'b1;
    end
    unique case (state_q)
      IDLE: begin
        duty_d = '0;
        if (bus.in_enable) state_d = RISE;
      end
      RISE: begin
        if (tick) begin
          // fade-out continues from the current level
          if (!bus.in_enable) begin
            duty_d  = dn_duty;
            step_d  = dn_step;
            hold_d  = '0;
            state_d = dn_last ? HOLD_LO : FALL;
          end else begin
            duty_d = up_step ? duty_q + ONE : duty_q;
            step_d = up_step;
            if (up_last) begin
              state_d = HOLD_HI;
              hold_d  = '0;
            end
          end
        end
      end
      HOLD_HI: begin
        if (tick) begin
          if (!bus.in_enable || hold_end) begin
            state_d = FALL;
            hold_d  = '0;
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end
      end
      FALL: begin
        if (tick) begin
          duty_d = dn_duty;
          step_d = dn_step;
          if (dn_last) begin
            state_d = HOLD_LO;
            hold_d  = '0;
          end
        end
      end
      HOLD_LO: begin
        if (tick) begin
          if (hold_end) begin
            done_d  = 1'b1;
            hold_d  = '0;
            state_d = bus.in_enable ? RISE : IDLE;
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        duty_d  = '0;
        hold_d  = '0;
      end
    endcase
  end

  assign bus.out_duty       = duty_q;
  assign bus.out_step       = step_q;
  assign bus.out_phase      = state_q;
  assign bus.out_cycle_done = done_q;

  a_step_moves: assert property (
    @(posedge in_clk) disable iff (in_rst)
    step_q |-> (duty_q != $past(duty_q)));

  a_done_pulse: assert property (
    @(posedge in_clk) disable iff (in_rst)
    done_q |=> !done_q);

  a_idle_zero: assert property (
    @(posedge in_clk) disable iff (in_rst)
    (state_q == IDLE) |-> (duty_q == '0));

endmodule
